mul_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one 8x8 `ary_mul` array multiplier between `NREQ` independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, registers the operands into the multiplier, registers the 16-bit product and returns it tagged with the requester index. It sits between the requesting datapath blocks and the single combinational multiplier instance.

---
 rtl/mul_share_pkg.sv | 14 +
 rtl/mul_share_arb_ary_mul.sv | 13 +
 rtl/mul_share_arb.sv | 104 ++++++++++
 tb/tb_mul_share_arb.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared constants and state encoding for the shared multiplier arbiter.
// Imported by the arbiter and the array multiplier.
package mul_share_pkg;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mul_share_arb_ary_mul.sv
// Combinational unsigned W x W array multiplier.
// Full-width product, no truncation.
module ary_mul
  import mul_share_pkg::*;
(
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [PW-1:0] out
);

  assign out = PW'(a) * PW'(b);

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one ary_mul between NREQ requesters.
// One operation in flight: IDLE grants, MUL computes, RESP returns.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [PW-1:0]     rsp_data,
  output logic              busy
);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  cur_id;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  nxt_ptr;
  logic            any;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [PW-1:0]   res;
  logic [PW-1:0]   prod;
  logic [NREQ-1:0] one;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        gnt = IDW'(idx);
      end
    end
  end

  assign one       = {{(NREQ-1){1'b0}}, 1'b1};
  assign req_ready = (state == IDLE && any) ? (one << gnt) : '0;
  assign nxt_ptr   = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
  assign rsp_data  = res;
  assign rsp_id    = cur_id;

  ary_mul u_mul (
    .a   (op_a),
    .b   (op_b),
    .out (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            op_a   <= req_a[int'(gnt)*W +: W];
            op_b   <= req_b[int'(gnt)*W +: W];
            cur_id <= gnt;
            ptr    <= nxt_ptr;
            busy   <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          res       <= prod;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed self-checking bench for mul_share_arb.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_mul_share_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        busy;

  int checks;
  int errors;

  mul_share_arb #(.NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_a     = 16'hFFFF;
    req_b     = 16'hFFFF;
    repeat (2) tick();
    checks++;
    if ({rsp_valid, busy, rsp_id, rsp_data} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outs: got v=%b busy=%b id=%0d data=%0d want all 0",
               rsp_valid, busy, rsp_id, rsp_data);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready_idle: got %b want 00", req_ready);
    end
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL reset_ready_grant: got %b want 10", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    req_a = {8'd0, 8'd12};
    req_b = {8'd0, 8'd13};
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    #1;
    checks++;
    if ({busy, rsp_valid, req_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL single_mul: got busy=%b v=%b rdy=%b want 1 0 00",
               busy, rsp_valid, req_ready);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 16'd156}) begin
      errors++;
      $display("FAIL single_rsp: got v=%b id=%0d data=%0d want 1 0 156",
               rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got v=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req_a = {8'd255, 8'd7};
    req_b = {8'd255, 8'd9};
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL cont_first_grant: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL cont_r1_wait: cycle %0d got %b want 0", i, req_ready[1]);
      end
      tick();
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 16'd63}) begin
      errors++;
      $display("FAIL cont_rsp0: got v=%b id=%0d data=%0d want 1 0 63",
               rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL cont_second_grant: got %b want 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 16'd65025}) begin
      errors++;
      $display("FAIL cont_rsp1: got v=%b id=%0d data=%0d want 1 1 65025",
               rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    int last;
    logic [15:0] exp;
    do_reset();
    req_a = {8'd5, 8'd3};
    req_b = {8'd6, 8'd4};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    n = 0;
    last = 0;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      tick();
      if (rsp_valid === 1'b1) begin
        exp = (n % 2 == 0) ? 16'd12 : 16'd30;
        checks++;
        if (rsp_id !== 1'(n % 2) || rsp_data !== exp) begin
          errors++;
          $display("FAIL b2b_order: rsp %0d got id=%0d data=%0d want %0d %0d",
                   n, rsp_id, rsp_data, n % 2, exp);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last !== 3) begin
            errors++;
            $display("FAIL b2b_spacing: rsp %0d got %0d want 3", n, cyc - last);
          end
        end
        last = cyc;
        n++;
      end
    end
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 6", n);
    end
    req_valid = 2'b00;
    repeat (4) tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    req_a = {8'd9, 8'd200};
    req_b = {8'd9, 8'd3};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b11;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, req_ready} !==
          {1'b1, 1'b0, 16'd600, 2'b00}) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got v=%b id=%0d data=%0d rdy=%b",
                 i, rsp_valid, rsp_id, rsp_data, req_ready);
      end
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({busy, rsp_valid, req_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL stall_release: got busy=%b v=%b rdy=%b want 0 0 10",
               busy, rsp_valid, req_ready);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    req_a = {8'd4, 8'd2};
    req_b = {8'd4, 8'd2};
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_no_rsp: got %0d rsp cycles want 0", seen);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL midreset_ptr: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    repeat (3) tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0]  bv [8];
    logic [7:0]  b;
    logic [15:0] exp;
    int          wait_n;
    do_reset();
    for (int a = 0; a < 256; a++) begin
      bv[0] = 8'd0;
      bv[1] = 8'd1;
      bv[2] = 8'd255;
      bv[3] = 8'd128;
      bv[4] = 8'(a);
      bv[5] = ~8'(a);
      bv[6] = 8'(a * 7 + 3);
      bv[7] = 8'd85;
      for (int j = 0; j < 8; j++) begin
        b = bv[j];
        exp = 16'(a) * 16'(b);
        req_a = {8'(a), 8'd0};
        req_b = {b, 8'd0};
        req_valid = 2'b10;
        rsp_ready = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
          errors++;
          $display("FAIL sweep_ready: a=%0d b=%0d got %b want 10",
                   a, b, req_ready);
        end
        tick();
        req_valid = 2'b00;
        wait_n = 0;
        while (rsp_valid !== 1'b1 && wait_n < 6) begin
          rsp_ready = 1'($urandom_range(0, 1));
          tick();
          wait_n++;
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, exp}) begin
          errors++;
          $display("FAIL sweep_rsp: a=%0d b=%0d got v=%b id=%0d data=%0d want %0d",
                   a, b, rsp_valid, rsp_id, rsp_data, exp);
        end
        rsp_ready = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
